rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter NUM_STAGES, default 4, number of sequenced reset stages (2..8).
REQ-002 Parameter HOLD_CYCLES, default 16, minimum cycles all stage resets stay asserted (>=1).
REQ-003 Parameter GAP_CYCLES, default 8, minimum cycles between consecutive stage releases (>=1).
REQ-004 Parameter TIMEOUT_CYCLES, default 64, max cycles to wait for a stage ready (>GAP_CYCLES).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high block reset.
REQ-007 sw_rst_req  input  1  one-cycle request to re-run the whole reset sequence.
REQ-008 stage_rdy  input  NUM_STAGES  per-stage "out of reset and ready" flag, synchronous to clk.
REQ-009 stage_rst  output  NUM_STAGES  synchronous, active-high reset to each stage; bit 0 released first.
REQ-010 busy  output  1  high while a sequence is in progress or halted in error.
REQ-011 seq_done  output  1  one-cycle pulse when the last stage is released and ready.
REQ-012 err  output  1  sticky timeout flag.
REQ-013 err_stage  output  3  index of the stage that timed out.
REQ-014 All outputs registered; no combinational input-to-output path.

Function
REQ-015 FSM states: ASSERT, RELEASE, IDLE, ERROR; one cycle counter cnt, one stage index k.
REQ-016 ASSERT: stage_rst all ones, busy=1; cnt increments each cycle from 0; at the edge where cnt==HOLD_CYCLES-1, clear stage_rst[0], set k=0, cnt=0, go RELEASE.
REQ-017 RELEASE: cnt increments each cycle; on the edge where cnt>=GAP_CYCLES-1 and stage_rdy[k]==1, advance: if k<NUM_STAGES-1, clear stage_rst[k+1], k=k+1, cnt=0; else go IDLE.
REQ-018 RELEASE->IDLE transition: busy=0 and seq_done=1 for exactly the next cycle; stage_rst all zeros.
REQ-019 RELEASE timeout: on the edge where cnt==TIMEOUT_CYCLES-1 without advancing, go ERROR, err=1, err_stage=k; stages >k stay in reset, stages <=k stay released.
REQ-020 ERROR: busy=1, outputs hold; exits only on sw_rst_req or rst.
REQ-021 IDLE: stage_rst all zeros, busy=0; stage_rdy deassertion in IDLE is ignored.
REQ-022 sw_rst_req in any state (including mid-RELEASE and ERROR) -> next edge: ASSERT, cnt=0, stage_rst all ones, busy=1, err=0, err_stage=0.
REQ-023 sw_rst_req coincident with an advance or timeout edge: sw_rst_req wins.
REQ-024 stage_rst bits never reassert individually; reassertion is always all bits together.
REQ-025 seq_done never asserts in the same cycle as err or while any stage_rst bit is 1.

Reset
REQ-026 rst==1 dominates every other input at the same edge.
REQ-027 rst values: state=ASSERT, cnt=0, k=0, stage_rst all ones, busy=1, seq_done=0, err=0, err_stage=0.
REQ-028 Sequence starts automatically on the first edge with rst==0; no request needed.

Verification
REQ-029 Defaults, stage_rdy=4'b1111, rst dropped before edge 1 -> stage_rst[0] low after edge 16, [1] after 24, [2] after 32, [3] after 40; seq_done pulses and busy falls after edge 48.
REQ-030 Defaults, stage_rdy[1] rises 20 cycles after stage_rst[1] clears -> stage_rst[2] clears on that rdy edge (not earlier); rest of sequence shifts by 12 cycles.
REQ-031 Defaults, stage_rdy[2] held 0 -> after 64 cycles in RELEASE k=2: err=1, err_stage=2, stage_rst=4'b1000, busy=1, no seq_done.
REQ-032 From REQ-031 error, pulse sw_rst_req -> next cycle err=0, stage_rst=4'b1111; full sequence completes as REQ-029.
REQ-033 sw_rst_req mid-RELEASE (k=1) -> next cycle stage_rst=4'b1111, cnt restarts; stage_rst[0] clears 16 cycles later.
REQ-034 rst asserted for one cycle in IDLE, same edge as sw_rst_req -> reset values of REQ-027, then sequence as REQ-029.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staged reset sequencer with hold, inter-stage gap, ready handshake and timeout.
module rst_seq_ctrl #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_rdy,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  busy,
  output logic                  seq_done,
  output logic                  err,
  output logic [2:0]            err_stage
);
  localparam int CMAX = HOLD_CYCLES > TIMEOUT_CYCLES ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int KW   = $clog2(NUM_STAGES);
  typedef enum logic [1:0] {ASSERT, RELEASE, IDLE, ERROR} state_t;
  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [KW-1:0]         k, k_d;
  logic [NUM_STAGES-1:0] stage_rst_d;
  logic                  busy_d, seq_done_d, err_d;
  logic [2:0]            err_stage_d;
  logic                  advance, last;
  assign advance = cnt >= CW'(GAP_CYCLES - 1) && stage_rdy[k];
  assign last    = k == KW'(NUM_STAGES - 1);
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    k_d         = k;
    stage_rst_d = stage_rst;
    busy_d      = busy;
    seq_done_d  = 1'b0;
    err_d       = err;
    err_stage_d = err_stage;
    if (sw_rst_req) begin
      state_d     = ASSERT;
      cnt_d       = '0;
      k_d         = '0;
      stage_rst_d = '1;
      busy_d      = 1'b1;
      err_d       = 1'b0;
      err_stage_d = '0;
    end else begin
      case (state)
        ASSERT: begin
          busy_d      = 1'b1;
          stage_rst_d = '1;
          cnt_d       = cnt + 1'b1;
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            state_d        = RELEASE;
            stage_rst_d[0] = 1'b0;
            k_d            = '0;
            cnt_d          = '0;
          end
        end
        RELEASE: begin
          cnt_d = cnt + 1'b1;
          // an advance on the timeout edge still counts as progress
          if (advance && !last) begin
            stage_rst_d = stage_rst & ~(NUM_STAGES'(2) << k);
            k_d         = k + 1'b1;
            cnt_d       = '0;
          end else if (advance) begin
            state_d     = IDLE;
            stage_rst_d = '0;
            busy_d      = 1'b0;
            seq_done_d  = 1'b1;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d     = ERROR;
            err_d       = 1'b1;
            err_stage_d = 3'(k);
          end
        end
        IDLE: begin
          stage_rst_d = '0;
          busy_d      = 1'b0;
        end
        default: busy_d = 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ASSERT;
      cnt       <= '0;
      k         <= '0;
      stage_rst <= '1;
      busy      <= 1'b1;
      seq_done  <= 1'b0;
      err       <= 1'b0;
      err_stage <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      k         <= k_d;
      stage_rst <= stage_rst_d;
      busy      <= busy_d;
      seq_done  <= seq_done_d;
      err       <= err_d;
      err_stage <= err_stage_d;
    end
  end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: table-driven checkpoints and hand sequences for rst_seq_ctrl, checked through a scoreboard queue.
module tb_rst_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst, sw_rst_req;
  logic [3:0] stage_rdy, stage_rst;
  logic       busy, seq_done, err;
  logic [2:0] err_stage;
  int         passed = 0, total = 0;
  typedef struct {
    string      name;
    logic [3:0] sr;
    logic       b, d, e;
    logic [2:0] es;
  } exp_t;
  typedef struct {
    int         sc, ed;
    logic [3:0] sr;
    logic       b, d, e;
    logic [2:0] es;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[$];
  rst_seq_ctrl dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .stage_rdy(stage_rdy),
    .stage_rst(stage_rst), .busy(busy), .seq_done(seq_done), .err(err), .err_stage(err_stage)
  );
  always #5 clk = ~clk;
  task automatic expect_out(input string name, input logic [3:0] sr, input logic b, d, e, input logic [2:0] es);
    exp_t x;
    x.name = name; x.sr = sr; x.b = b; x.d = d; x.e = e; x.es = es;
    sb.push_back(x);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t x = sb.pop_front();
      total++;
      if ({stage_rst, busy, seq_done, err, err_stage} === {x.sr, x.b, x.d, x.e, x.es}) passed++;
      else $display("FAIL %s: got rst=%b busy=%b done=%b err=%b es=%0d, want rst=%b busy=%b done=%b err=%b es=%0d",
                    x.name, stage_rst, busy, seq_done, err, err_stage, x.sr, x.b, x.d, x.e, x.es);
    end
  endtask
  function automatic logic [3:0] rdy_of(input int sc, input int ed);
    return sc == 1 ? (ed >= 44 ? 4'b1111 : 4'b1101) : sc == 2 ? 4'b1011 : 4'b1111;
  endfunction
  task automatic run_seq(input int sc, input int n);
    for (int e = 1; e <= n; e++) begin
      stage_rdy = rdy_of(sc, e);
      foreach (tbl[i])
        if (tbl[i].sc == sc && tbl[i].ed == e)
          expect_out($sformatf("sc%0d_e%0d", sc, e), tbl[i].sr, tbl[i].b, tbl[i].d, tbl[i].e, tbl[i].es);
      tick();
    end
  endtask
  task automatic do_reset(input string name);
    rst = 1'b1;
    expect_out(name, 4'b1111, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    rst = 1'b0;
  endtask
  initial begin
    tbl = '{
      '{0, 15, 4'b1111, 1, 0, 0, 0}, '{0, 16, 4'b1110, 1, 0, 0, 0}, '{0, 23, 4'b1110, 1, 0, 0, 0},
      '{0, 24, 4'b1100, 1, 0, 0, 0}, '{0, 31, 4'b1100, 1, 0, 0, 0}, '{0, 32, 4'b1000, 1, 0, 0, 0},
      '{0, 39, 4'b1000, 1, 0, 0, 0}, '{0, 40, 4'b0000, 1, 0, 0, 0}, '{0, 47, 4'b0000, 1, 0, 0, 0},
      '{0, 48, 4'b0000, 0, 1, 0, 0}, '{0, 49, 4'b0000, 0, 0, 0, 0},
      '{1, 24, 4'b1100, 1, 0, 0, 0}, '{1, 43, 4'b1100, 1, 0, 0, 0}, '{1, 44, 4'b1000, 1, 0, 0, 0},
      '{1, 51, 4'b1000, 1, 0, 0, 0}, '{1, 52, 4'b0000, 1, 0, 0, 0}, '{1, 59, 4'b0000, 1, 0, 0, 0},
      '{1, 60, 4'b0000, 0, 1, 0, 0}, '{1, 61, 4'b0000, 0, 0, 0, 0},
      '{2, 32, 4'b1000, 1, 0, 0, 0}, '{2, 95, 4'b1000, 1, 0, 0, 0}, '{2, 96, 4'b1000, 1, 0, 1, 2},
      '{2, 110, 4'b1000, 1, 0, 1, 2}
    };
    rst = 1'b1; sw_rst_req = 1'b0; stage_rdy = 4'b1111;
    do_reset("reset0");
    rst = 1'b1;
    do_reset("reset1");
    run_seq(0, 49);
    stage_rdy = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      expect_out("idle_rdy_drop", 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
      tick();
    end
    sw_rst_req = 1'b1;
    do_reset("rst_over_sw");
    sw_rst_req = 1'b0;
    run_seq(0, 49);
    do_reset("reset_sc1");
    run_seq(1, 61);
    do_reset("reset_sc2");
    run_seq(2, 110);
    sw_rst_req = 1'b1;
    stage_rdy = 4'b1111;
    expect_out("sw_from_error", 4'b1111, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    sw_rst_req = 1'b0;
    run_seq(0, 49);
    do_reset("reset_mid");
    run_seq(0, 29);
    sw_rst_req = 1'b1;
    expect_out("sw_mid_release", 4'b1111, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    sw_rst_req = 1'b0;
    run_seq(0, 49);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
